// File: rtl/audio_pcm_sched.sv
// Purpose : paces PCM playback with a phase accumulator and unpacks 1-4 FIFO bytes per due
//           frame into left-justified signed L/R samples for the I2S DAC.
// Latency : a frame is due on the cycle after next_sample; N fetch cycles + 1 load cycle (N = 1..4).
// Backpres: pops only while the show-ahead FIFO is non-empty; running dry mid-frame aborts the
//           frame, zeroes both samples and sets the sticky underrun flag.
//
// Ports   : clk, rst (async, active-high)
//           next_sample  - frame request from the DAC interface (1-cycle pulse)
//           cfg_rate     - playback rate, 2**ACC_W = one frame per request, 0 = paused
//           cfg_16bit    - 16-bit little-endian samples (else 8-bit)
//           cfg_stereo   - interleaved L/R (else mono, duplicated to both channels)
//           underrun_clr - clears the sticky underrun flag
//           fifo_rddata / fifo_empty / fifo_rd - show-ahead PCM FIFO read side
//           left_data / right_data - samples to the DAC
//           underrun     - sticky FIFO-empty-during-fetch flag
//           busy         - frame fetch or load in progress
module audio_pcm_sched #(
    parameter int ACC_W    = 7,
    parameter int SAMPLE_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                next_sample,
    input  logic [ACC_W:0]      cfg_rate,
    input  logic                cfg_16bit,
    input  logic                cfg_stereo,
    input  logic                underrun_clr,
    input  logic [7:0]          fifo_rddata,
    input  logic                fifo_empty,
    output logic                fifo_rd,
    output logic [SAMPLE_W-1:0] left_data,
    output logic [SAMPLE_W-1:0] right_data,
    output logic                underrun,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [ACC_W:0] FULL_SCALE = {1'b1, {ACC_W{1'b0}}};

    state_t              state;
    state_t              state_nxt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W:0]      rate_eff;
    logic [ACC_W:0]      sum;
    logic                carry;
    logic                start;
    logic                abort;
    logic                fmt16;
    logic                stereo;
    logic [1:0]          k;
    logic [1:0]          k_last;
    logic [3:0][7:0]     byte_q;
    logic [15:0]         word_l;
    logic [15:0]         word_r;
    logic [SAMPLE_W-1:0] samp_l;
    logic [SAMPLE_W-1:0] samp_r;

    // Rates above full scale would wrap the accumulator sum, so clamp them.
    assign rate_eff = (cfg_rate > FULL_SCALE) ? FULL_SCALE : cfg_rate;
    assign sum      = {1'b0, acc} + rate_eff;
    assign carry    = next_sample & sum[ACC_W];
    // A carry arriving while a frame is still in flight is simply lost.
    assign start    = carry && (state == IDLE);
    assign abort    = (state == FETCH) && fifo_empty;

    assign fifo_rd  = (state == FETCH) && !fifo_empty;
    assign busy     = (state != IDLE);

    // Index of the final byte of the frame: 8m=0, 8s=1, 16m=1, 16s=3.
    assign k_last   = {fmt16 & stereo, fmt16 | stereo};

    // Byte slots: 8-bit uses b0 (L) / b1 (R); 16-bit uses b1:b0 (L) / b3:b2 (R).
    assign word_l   = fmt16 ? {byte_q[1], byte_q[0]} : {byte_q[0], 8'h00};
    assign word_r   = fmt16 ? {byte_q[3], byte_q[2]} : {byte_q[1], 8'h00};
    assign samp_l   = SAMPLE_W'(word_l) << (SAMPLE_W - 16);
    assign samp_r   = stereo ? (SAMPLE_W'(word_r) << (SAMPLE_W - 16)) : samp_l;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (next_sample) begin
            acc <= sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (fifo_empty) begin
                    state_nxt = IDLE;
                end else if (k == k_last) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fmt16      <= 1'b0;
            stereo     <= 1'b0;
            k          <= 2'd0;
            byte_q     <= '0;
            left_data  <= '0;
            right_data <= '0;
            underrun   <= 1'b0;
        end else begin
            // Format is frozen for the whole frame; later config edits wait for the next one.
            if (start) begin
                fmt16  <= cfg_16bit;
                stereo <= cfg_stereo;
                k      <= 2'd0;
            end
            if (fifo_rd) begin
                byte_q[k] <= fifo_rddata;
                k         <= k + 2'd1;
            end
            // Setting has priority over a coincident clear.
            if (abort) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
            if (abort) begin
                left_data  <= '0;
                right_data <= '0;
            end else if (state == LOAD) begin
                left_data  <= samp_l;
                right_data <= samp_r;
            end
        end
    end

endmodule

// File: tb/tb_audio_pcm_sched.sv
// Purpose : directed self-checking bench for audio_pcm_sched with a show-ahead FIFO model.
// Latency : checks frame completion cycle count and per-frame pop counts.
// Backpres: FIFO model pops one byte per cycle that fifo_rd is high and it is non-empty.
module tb_audio_pcm_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        next_sample;
    logic [7:0]  cfg_rate;
    logic        cfg_16bit;
    logic        cfg_stereo;
    logic        underrun_clr;
    logic [7:0]  fifo_rddata;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [23:0] left_data;
    logic [23:0] right_data;
    logic        underrun;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // FIFO model
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    logic       flush  = 1'b0;
    int         pops   = 0;

    always #5 clk = ~clk;

    assign fifo_empty  = (rd_ptr == wr_ptr);
    assign fifo_rddata = mem[rd_ptr];

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd && !fifo_empty) begin
            rd_ptr <= rd_ptr + 8'd1;
            pops   <= pops + 1;
        end
    end

    audio_pcm_sched #(.ACC_W(7), .SAMPLE_W(24)) dut (
        .clk(clk), .rst(rst), .next_sample(next_sample), .cfg_rate(cfg_rate),
        .cfg_16bit(cfg_16bit), .cfg_stereo(cfg_stereo), .underrun_clr(underrun_clr),
        .fifo_rddata(fifo_rddata), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .left_data(left_data), .right_data(right_data), .underrun(underrun), .busy(busy)
    );

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic do_flush();
        @(negedge clk) flush = 1'b1;
        @(negedge clk) flush = 1'b0;
    endtask

    task automatic pulse();
        @(negedge clk) next_sample = 1'b1;
        @(negedge clk) next_sample = 1'b0;
    endtask

    // Counts negedges until busy drops; a hung frame shows up as 20.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic set_cfg(input logic [7:0] rate, input logic f16, input logic st);
        cfg_rate = rate; cfg_16bit = f16; cfg_stereo = st;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (fifo_rd !== 1'b0) begin failures++; $display("FAIL reset_fifo_rd got=%b exp=0", fifo_rd); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        checks++; if (left_data !== 24'h0 || right_data !== 24'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", left_data, right_data); end
        rst = 1'b0;
        flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_16st();
        int p0, cyc;
        set_cfg(8'd128, 1'b1, 1'b1);
        push(8'h34); push(8'h12); push(8'h78); push(8'h56);
        p0 = pops;
        pulse();
        wait_idle(cyc);
        checks++; if (cyc != 5) begin failures++; $display("FAIL t16st_latency got=%0d exp=5", cyc); end
        checks++; if (pops - p0 != 4) begin failures++; $display("FAIL t16st_pops got=%0d exp=4", pops - p0); end
        checks++; if (left_data !== 24'h123400) begin failures++; $display("FAIL t16st_left got=%h exp=123400", left_data); end
        checks++; if (right_data !== 24'h567800) begin failures++; $display("FAIL t16st_right got=%h exp=567800", right_data); end
    endtask

    task automatic test_half_rate();
        int p0, cyc;
        set_cfg(8'd64, 1'b0, 1'b0);
        push(8'h80); push(8'h7F);
        p0 = pops;
        pulse(); wait_idle(cyc);
        checks++; if (pops - p0 != 0) begin failures++; $display("FAIL half_p1_pops got=%0d exp=0", pops - p0); end
        pulse(); wait_idle(cyc);
        checks++; if (pops - p0 != 1) begin failures++; $display("FAIL half_p2_pops got=%0d exp=1", pops - p0); end
        checks++; if (left_data !== 24'h800000 || right_data !== 24'h800000) begin failures++; $display("FAIL half_p2_data got=%h/%h exp=800000/800000", left_data, right_data); end
        pulse(); wait_idle(cyc);
        checks++; if (pops - p0 != 1) begin failures++; $display("FAIL half_p3_pops got=%0d exp=1", pops - p0); end
        pulse(); wait_idle(cyc);
        checks++; if (pops - p0 != 2) begin failures++; $display("FAIL half_p4_pops got=%0d exp=2", pops - p0); end
        checks++; if (left_data !== 24'h7F0000 || right_data !== 24'h7F0000) begin failures++; $display("FAIL half_p4_data got=%h/%h exp=7f0000/7f0000", left_data, right_data); end
    endtask

    task automatic test_underrun();
        int p0, cyc;
        set_cfg(8'd128, 1'b1, 1'b1);
        push(8'hAB); push(8'hCD);
        p0 = pops;
        pulse(); wait_idle(cyc);
        checks++; if (cyc != 3) begin failures++; $display("FAIL under_latency got=%0d exp=3", cyc); end
        checks++; if (pops - p0 != 2) begin failures++; $display("FAIL under_pops got=%0d exp=2", pops - p0); end
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL under_flag got=%b exp=1", underrun); end
        checks++; if (left_data !== 24'h0 || right_data !== 24'h0) begin failures++; $display("FAIL under_data got=%h/%h exp=0/0", left_data, right_data); end
        // Clear coincides with a fresh abort on the empty FIFO.
        @(negedge clk) next_sample = 1'b1;
        @(negedge clk) begin next_sample = 1'b0; underrun_clr = 1'b1; end
        @(negedge clk) underrun_clr = 1'b0;
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL under_set_wins got=%b exp=1", underrun); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL under_busy got=%b exp=0", busy); end
        @(negedge clk) underrun_clr = 1'b1;
        @(negedge clk) underrun_clr = 1'b0;
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL under_clr got=%b exp=0", underrun); end
    endtask

    task automatic test_paused();
        int p0, cyc;
        set_cfg(8'd128, 1'b0, 1'b1);
        push(8'h11); push(8'h22);
        pulse(); wait_idle(cyc);
        checks++; if (left_data !== 24'h110000 || right_data !== 24'h220000) begin failures++; $display("FAIL pause_pre got=%h/%h exp=110000/220000", left_data, right_data); end
        set_cfg(8'd0, 1'b0, 1'b1);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        p0 = pops;
        repeat (10) pulse();
        checks++; if (pops - p0 != 0) begin failures++; $display("FAIL pause_pops got=%0d exp=0", pops - p0); end
        checks++; if (left_data !== 24'h110000 || right_data !== 24'h220000) begin failures++; $display("FAIL pause_hold got=%h/%h exp=110000/220000", left_data, right_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pause_busy got=%b exp=0", busy); end
        do_flush();
    endtask

    task automatic test_reset_mid_fetch();
        int p0, cyc;
        set_cfg(8'd96, 1'b1, 1'b1);
        push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
        p0 = pops;
        pulse(); wait_idle(cyc);
        pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (pops - p0 != 1) begin failures++; $display("FAIL rstmid_pops got=%0d exp=1", pops - p0); end
        checks++; if (fifo_rd !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got rd=%b busy=%b exp=0/0", fifo_rd, busy); end
        checks++; if (left_data !== 24'h0 || right_data !== 24'h0) begin failures++; $display("FAIL rstmid_data got=%h/%h exp=0/0", left_data, right_data); end
        @(negedge clk) rst = 1'b0;
        do_flush();
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        set_cfg(8'd64, 1'b1, 1'b1);
        p0 = pops;
        pulse(); wait_idle(cyc);
        checks++; if (pops - p0 != 0) begin failures++; $display("FAIL rstmid_acc got=%0d pops exp=0", pops - p0); end
        pulse(); wait_idle(cyc);
        checks++; if (pops - p0 != 4) begin failures++; $display("FAIL rstmid_fresh_pops got=%0d exp=4", pops - p0); end
        checks++; if (left_data !== 24'h020100 || right_data !== 24'h040300) begin failures++; $display("FAIL rstmid_fresh_data got=%h/%h exp=020100/040300", left_data, right_data); end
    endtask

    task automatic test_clamp();
        int p0, cyc;
        set_cfg(8'd200, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            push(8'h01); push(8'hFF);
        end
        for (int i = 0; i < 3; i++) begin
            p0 = pops;
            pulse(); wait_idle(cyc);
            checks++; if (pops - p0 != 2) begin failures++; $display("FAIL clamp_pops[%0d] got=%0d exp=2", i, pops - p0); end
            checks++; if (left_data !== 24'h010000 || right_data !== 24'hFF0000) begin failures++; $display("FAIL clamp_data[%0d] got=%h/%h exp=010000/ff0000", i, left_data, right_data); end
        end
    endtask

    task automatic test_back_to_back();
        int p0, cyc;
        set_cfg(8'd128, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) push(8'(i));
        p0 = pops;
        @(negedge clk) next_sample = 1'b1;
        @(negedge clk) begin cfg_16bit = 1'b0; cfg_stereo = 1'b0; end
        @(negedge clk) next_sample = 1'b0;
        wait_idle(cyc);
        repeat (5) @(negedge clk);
        checks++; if (pops - p0 != 4) begin failures++; $display("FAIL b2b_pops got=%0d exp=4", pops - p0); end
        checks++; if (left_data !== 24'h020100 || right_data !== 24'h040300) begin failures++; $display("FAIL b2b_data got=%h/%h exp=020100/040300", left_data, right_data); end
        do_flush();
    endtask

    initial begin
        rst = 1'b1;
        next_sample = 1'b0;
        underrun_clr = 1'b0;
        set_cfg(8'd0, 1'b0, 1'b0);
        test_reset();
        test_16st();
        test_half_rate();
        test_underrun();
        test_paused();
        test_reset_mid_fetch();
        test_clamp();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
